// File: rtl/fnd_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment bus.
// Decodes settled (com, data) samples back to BCD digits and dot flags, then publishes complete frames.
module fnd_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  i_fnd_com,
    input  logic [7:0]  i_fnd_data,
    output logic [15:0] o_frame_bcd,
    output logic [3:0]  o_frame_dp,
    output logic        o_frame_valid,
    output logic        o_stale,
    output logic        o_seg_err,
    output logic        o_com_err
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]    r_com_m, r_com_s, r_com_p;
    logic [7:0]    r_data_m, r_data_s, r_data_p;
    logic [SW-1:0] r_settle;
    logic [TW-1:0] r_tmo;
    logic          r_stale;
    logic [15:0]   r_shadow;
    logic [3:0]    r_seen, r_dpacc;
    logic [15:0]   r_frame_bcd;
    logic [3:0]    r_frame_dp;
    logic          r_frame_valid, r_seg_err, r_com_err;

    logic          w_com_chg, w_pair_chg, w_cap;
    logic          w_seg_ok, w_blank, w_dp;
    logic [3:0]    w_val;
    logic          w_pos_ok, w_idle;
    logic [1:0]    w_pos;
    logic [3:0]    w_seen_base, w_dp_base;

    // Two-flop synchronizer plus a copy of the last synced pair for change detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_com_m  <= 4'hF;
            r_com_s  <= 4'hF;
            r_com_p  <= 4'hF;
            r_data_m <= 8'hFF;
            r_data_s <= 8'hFF;
            r_data_p <= 8'hFF;
        end else begin
            r_com_m  <= i_fnd_com;
            r_com_s  <= r_com_m;
            r_com_p  <= r_com_s;
            r_data_m <= i_fnd_data;
            r_data_s <= r_data_m;
            r_data_p <= r_data_s;
        end
    end

    assign w_com_chg  = (r_com_s != r_com_p);
    assign w_pair_chg = w_com_chg || (r_data_s != r_data_p);
    // Counter parks one past the capture point so a stable pair is captured only once.
    assign w_cap      = !w_pair_chg && (r_settle == SW'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle <= '0;
        end else if (w_pair_chg) begin
            r_settle <= '0;
        end else if (r_settle < SW'(SETTLE_CYCLES)) begin
            r_settle <= r_settle + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo   <= '0;
            r_stale <= 1'b0;
        end else if (w_com_chg) begin
            r_tmo   <= '0;
            r_stale <= 1'b0;
        end else if (r_tmo != TW'(TIMEOUT_CYCLES)) begin
            r_tmo <= r_tmo + TW'(1);
            if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                r_stale <= 1'b1;
            end
        end
    end

    // Segment pattern and digit-select decode of the synced sample.
    always_comb begin
        w_seg_ok = 1'b1;
        w_blank  = 1'b0;
        w_val    = 4'd0;
        w_dp     = ~r_data_s[7];
        case (r_data_s[6:0])
            7'h40:   w_val = 4'd0;
            7'h79:   w_val = 4'd1;
            7'h24:   w_val = 4'd2;
            7'h30:   w_val = 4'd3;
            7'h19:   w_val = 4'd4;
            7'h12:   w_val = 4'd5;
            7'h02:   w_val = 4'd6;
            7'h78:   w_val = 4'd7;
            7'h00:   w_val = 4'd8;
            7'h10:   w_val = 4'd9;
            7'h7F:   w_blank = 1'b1;
            default: w_seg_ok = 1'b0;
        endcase

        w_pos_ok = 1'b1;
        w_idle   = 1'b0;
        w_pos    = 2'd0;
        case (r_com_s)
            4'b1110: w_pos = 2'd0;
            4'b1101: w_pos = 2'd1;
            4'b1011: w_pos = 2'd2;
            4'b0111: w_pos = 2'd3;
            4'b1111: begin
                w_idle   = 1'b1;
                w_pos_ok = 1'b0;
            end
            default: w_pos_ok = 1'b0;
        endcase

        w_seen_base = (w_pos == 2'd0) ? 4'b0000 : r_seen;
        w_dp_base   = (w_pos == 2'd0) ? 4'b0000 : r_dpacc;
    end

    // Frame assembly: digit 0 always opens a new frame and publishes the previous one if complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow      <= '0;
            r_seen        <= '0;
            r_dpacc       <= '0;
            r_frame_bcd   <= '0;
            r_frame_dp    <= '0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_com_err     <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_cap && !w_idle && !w_pos_ok) begin
                r_com_err <= 1'b1;
            end
            if (w_cap && w_pos_ok && !w_seg_ok) begin
                r_seg_err <= 1'b1;
            end
            if (r_stale) begin
                r_seen  <= '0;
                r_dpacc <= '0;
            end else if (w_cap && w_pos_ok && w_seg_ok) begin
                if ((w_pos == 2'd0) && (r_seen == 4'b1111)) begin
                    r_frame_bcd   <= r_shadow;
                    r_frame_dp    <= r_dpacc;
                    r_frame_valid <= 1'b1;
                end
                r_dpacc <= w_dp_base | (4'(w_dp) << w_pos);
                if (w_blank) begin
                    r_seen <= w_seen_base;
                end else begin
                    r_seen                  <= w_seen_base | (4'b0001 << w_pos);
                    r_shadow[w_pos*4 +: 4] <= w_val;
                end
            end
        end
    end

    assign o_frame_bcd   = r_frame_bcd;
    assign o_frame_dp    = r_frame_dp;
    assign o_frame_valid = r_frame_valid;
    assign o_stale       = r_stale;
    assign o_seg_err     = r_seg_err;
    assign o_com_err     = r_com_err;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: expected frames are queued as scans are driven
// and matched against each frame_valid pulse.
module tb_fnd_scan_decoder;

    localparam int unsigned SETTLE  = 16;
    localparam int unsigned TMO     = 400;
    localparam int          HOLD    = 40;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic [15:0] frame_bcd;
    logic [3:0]  frame_dp;
    logic        frame_valid, stale, seg_err, com_err;

    int     n_checks = 0;
    int     n_errors = 0;
    frame_t exp_q[$];

    fnd_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_fnd_com    (fnd_com),
        .i_fnd_data   (fnd_data),
        .o_frame_bcd  (frame_bcd),
        .o_frame_dp   (frame_dp),
        .o_frame_valid(frame_valid),
        .o_stale      (stale),
        .o_seg_err    (seg_err),
        .o_com_err    (com_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] com, input logic [7:0] data, input int n);
        @(negedge clk);
        fnd_com  = com;
        fnd_data = data;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [15:0] bcd, input logic [3:0] dp);
        exp_q.push_back('{bcd: bcd, dp: dp});
    endtask

    // Scoreboard side: every frame_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (!reset && frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'(frame_bcd), 32'hFFFF_FFFF);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check("frame_bcd", 32'(frame_bcd), 32'(e.bcd));
                check("frame_dp", 32'(frame_dp), 32'(e.dp));
            end
        end
    end

    initial begin
        int waited;
        reset    = 1'b1;
        fnd_com  = 4'hF;
        fnd_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(frame_bcd), 32'h0);
        check("rst_flags", 32'({frame_dp, frame_valid, stale, seg_err, com_err}), 32'h0);
        reset = 1'b0;
        repeat (HOLD) @(negedge clk);

        // Basic scan 1,2,3,4 then digit 0 closes the frame.
        step(4'b1110, 8'hF9, HOLD);
        step(4'b1101, 8'hA4, HOLD);
        step(4'b1011, 8'hB0, HOLD);
        step(4'b0111, 8'h99, HOLD);
        expect_frame(16'h4321, 4'b0000);
        step(4'b1110, 8'hC0, HOLD);
        check("t1_errs", 32'({seg_err, com_err, stale}), 32'h0);
        check("t1_q_empty", 32'(exp_q.size()), 32'h0);

        // Extra blank phase on digit 2 with its dot lit.
        step(4'b1110, 8'hF9, HOLD);
        step(4'b1101, 8'hA4, HOLD);
        step(4'b1011, 8'hB0, HOLD);
        step(4'b0111, 8'h99, HOLD);
        step(4'b1011, 8'h7F, HOLD);
        expect_frame(16'h4321, 4'b0100);
        step(4'b1110, 8'hF9, HOLD);
        check("t2_q_empty", 32'(exp_q.size()), 32'h0);

        // Data glitching every cycle must never be captured.
        for (int i = 0; i < 5; i++) begin
            step(4'b1110, (i % 2 == 0) ? 8'hAA : 8'h55, 1);
        end
        step(4'b1110, 8'h92, HOLD);
        check("t3_no_seg_err", 32'(seg_err), 32'h0);
        step(4'b1101, 8'h82, HOLD);
        step(4'b1011, 8'hF8, HOLD);
        step(4'b0111, 8'h80, HOLD);
        expect_frame(16'h8765, 4'b0000);
        step(4'b1110, 8'hF9, HOLD);
        check("t3_q_empty", 32'(exp_q.size()), 32'h0);

        // Undecodable pattern on digit 1: frame withheld until digit 1 is seen valid.
        step(4'b1101, 8'hAA, HOLD);
        check("t4_seg_err", 32'(seg_err), 32'h1);
        step(4'b1011, 8'hB0, HOLD);
        step(4'b0111, 8'h99, HOLD);
        step(4'b1110, 8'hF9, HOLD);
        step(4'b1101, 8'hA4, HOLD);
        step(4'b1011, 8'hB0, HOLD);
        step(4'b0111, 8'h99, HOLD);
        expect_frame(16'h4321, 4'b0000);
        step(4'b1110, 8'hF9, HOLD);
        check("t4_seg_sticky", 32'(seg_err), 32'h1);
        check("t4_q_empty", 32'(exp_q.size()), 32'h0);

        // Two digits selected at once, then a frozen com line times out.
        step(4'b1100, 8'hF9, HOLD);
        check("t5_com_err", 32'(com_err), 32'h1);
        step(4'b1110, 8'hC0, TMO / 2);
        check("t5_not_stale_yet", 32'(stale), 32'h0);
        waited = 0;
        while (!stale && waited < TMO) begin
            @(negedge clk);
            waited++;
        end
        check("t5_stale", 32'(stale), 32'h1);
        check("t5_bcd_hold", 32'(frame_bcd), 32'h4321);
        step(4'b1111, 8'hFF, 6);
        check("t5_stale_clear", 32'(stale), 32'h0);
        check("t5_com_sticky", 32'(com_err), 32'h1);

        // Reset mid-frame discards partial state; next full scan publishes.
        step(4'b1110, 8'hF9, HOLD);
        step(4'b1101, 8'hA4, HOLD);
        step(4'b1011, 8'hB0, HOLD);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_rst_bcd", 32'(frame_bcd), 32'h0);
        check("t6_rst_flags", 32'({frame_dp, frame_valid, stale, seg_err, com_err}), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        step(4'b0111, 8'h99, HOLD);
        step(4'b1110, 8'hF9, HOLD);
        check("t6_no_frame", 32'(frame_bcd), 32'h0);
        step(4'b1101, 8'hA4, HOLD);
        step(4'b1011, 8'hB0, HOLD);
        step(4'b0111, 8'h99, HOLD);
        expect_frame(16'h4321, 4'b0000);
        step(4'b1110, 8'hC0, HOLD);
        check("t6_frame", 32'(frame_bcd), 32'h4321);
        check("final_q_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
